// File: rtl/mc_mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_port_pkg
// Description : Shared funct3 codes, FSM state encoding and legality helper
//               for the unified multi-cycle memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_mem_port_pkg;

    // Load size codes
    localparam logic [2:0] c_F3_LB  = 3'd0;
    localparam logic [2:0] c_F3_LH  = 3'd1;
    localparam logic [2:0] c_F3_LW  = 3'd2;
    localparam logic [2:0] c_F3_LBU = 3'd4;
    localparam logic [2:0] c_F3_LHU = 3'd5;

    // Store size codes
    localparam logic [2:0] c_F3_SB  = 3'd0;
    localparam logic [2:0] c_F3_SH  = 3'd1;
    localparam logic [2:0] c_F3_SW  = 3'd2;

    // Port sequencer states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_DONE     = 3'd3,
        S_ERR      = 3'd4
    } state_e;

    // Size/alignment legality of an access; fetches are always word accesses
    function automatic logic access_legal(input logic       is_fetch,
                                          input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (is_fetch) begin
            ok = (off == 2'b00);
        end else if (we) begin
            case (f3)
                c_F3_SB: ok = 1'b1;
                c_F3_SH: ok = (off[0] == 1'b0);
                c_F3_SW: ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                c_F3_LB, c_F3_LBU: ok = 1'b1;
                c_F3_LH, c_F3_LHU: ok = (off[0] == 1'b0);
                c_F3_LW:           ok = (off == 2'b00);
                default:           ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_port_align.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_port_align
// Description : Combinational load/store alignment: legality check, byte
//               enable and lane-replicated store data generation, and load
//               lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mem_port_align
    import mc_mem_port_pkg::*;
#(
    parameter int XLEN = 32
) (
    // Request side (decoded while the port is idle)
    input  logic            is_fetch_i,
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            legal_o,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    // Load side (uses the access fields latched at command time)
    input  logic            ld_fetch_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] rsp_word_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] w_shifted;

    // Legality, byte enables and store lane replication
    always_comb begin
        legal_o = access_legal(is_fetch_i, we_i, funct3_i, off_i);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (we_i && !is_fetch_i) begin
            case (funct3_i)
                c_F3_SB: begin
                    be_o    = 4'b0001 << off_i;
                    wdata_o = {(XLEN/8){wdata_i[7:0]}};
                end
                c_F3_SH: begin
                    be_o    = 4'b0011 << {off_i[1], 1'b0};
                    wdata_o = {(XLEN/16){wdata_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
            endcase
        end
    end

    // Move the addressed lane down to bit 0, then extend by load size
    always_comb begin
        w_shifted = rsp_word_i >> {ld_off_i, 3'b000};
        ld_data_o = rsp_word_i;
        if (!ld_fetch_i) begin
            case (ld_funct3_i)
                c_F3_LB:  ld_data_o = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
                c_F3_LH:  ld_data_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
                c_F3_LBU: ld_data_o = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
                c_F3_LHU: ld_data_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
                default:  ld_data_o = rsp_word_i;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_port
// Description : Unified instruction/data memory port for the multi-cycle
//               datapath. Runs a valid/ready command handshake with a
//               variable-latency memory, returns aligned/extended read data
//               and pulses done (with fault) back to the control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mem_port
    import mc_mem_port_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    // Control-unit side
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic            req_is_fetch_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            done_o,
    output logic            fault_o,
    output logic [XLEN-1:0] rdata_o,
    // Memory side
    output logic            mem_cmd_valid_o,
    input  logic            mem_cmd_ready_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic              fetch_q;
    logic [2:0]        f3_q;
    logic [3:0]        be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;

    logic              w_legal;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_accept;
    logic              w_capture;

    mc_mem_port_align #(
        .XLEN (XLEN)
    ) u_align (
        .is_fetch_i  (req_is_fetch_i),
        .we_i        (req_we_i),
        .funct3_i    (req_funct3_i),
        .off_i       (req_addr_i[1:0]),
        .wdata_i     (req_wdata_i),
        .legal_o     (w_legal),
        .be_o        (w_be),
        .wdata_o     (w_wdata),
        .ld_fetch_i  (fetch_q),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .rsp_word_i  (mem_rdata_i),
        .ld_data_o   (w_ld_data)
    );

    // A legal request is only taken from IDLE, so done/err cycles never accept
    assign w_accept  = (state_q == S_IDLE) && req_valid_i && w_legal;
    assign w_capture = (state_q == S_WAIT_RSP) && mem_rsp_valid_i;

    // Next-state and timeout-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = w_legal ? S_CMD : S_ERR;
                end
            end
            S_CMD: begin
                if (mem_cmd_ready_i) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RSP;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_RSP: begin
                // A response arriving on the timeout cycle still completes normally
                if (mem_rsp_valid_i) begin
                    state_d = S_DONE;
                end else if (cnt_q == c_TIMEOUT) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch command fields on acceptance; they stay stable through CMD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            f3_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (w_accept) begin
            addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
            off_q   <= req_addr_i[1:0];
            we_q    <= req_we_i;
            fetch_q <= req_is_fetch_i;
            f3_q    <= req_funct3_i;
            be_q    <= w_be;
            wdata_q <= w_wdata;
        end
    end

    // Read data register: updated only by a response while waiting for one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (w_capture) begin
            rdata_q <= w_ld_data;
        end
    end

    assign done_o          = (state_q == S_DONE) || (state_q == S_ERR);
    assign fault_o         = (state_q == S_ERR);
    assign rdata_o         = rdata_q;
    assign mem_cmd_valid_o = (state_q == S_CMD);
    assign mem_we_o        = mem_cmd_valid_o && we_q;
    assign mem_be_o        = mem_cmd_valid_o ? be_q : 4'b0000;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_mem_port
// Description : Directed self-checking bench for mc_mem_port with a
//               queue-based scoreboard on the done/fault/rdata response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_mem_port;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we, req_is_fetch;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        done, fault;
    logic [31:0] rdata;
    logic        mem_cmd_valid, mem_cmd_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    mc_mem_port #(
        .XLEN    (32),
        .TIMEOUT (255),
        .TO_W    (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_we_i        (req_we),
        .req_is_fetch_i  (req_is_fetch),
        .req_funct3_i    (req_funct3),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .done_o          (done),
        .fault_o         (fault),
        .rdata_o         (rdata),
        .mem_cmd_valid_o (mem_cmd_valid),
        .mem_cmd_ready_i (mem_cmd_ready),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_be_o        (mem_be),
        .mem_wdata_o     (mem_wdata),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rdata_i     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected response
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_fault", {31'd0, fault}, {31'd0, e.fault});
                chk("sb_rdata", rdata, e.rdata);
            end
        end
    end

    // One access as driven by the control unit, with a simple memory model
    task automatic do_access(input string nm,
                             input logic we, input logic fetch, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int rdy_dly, input logic give_rsp,
                             input logic [31:0] rsp_word,
                             input logic exp_fault, input logic [31:0] exp_rd,
                             input logic exp_cmd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int exp_edges);
        exp_t e;
        int   edges;
        int   waited;
        int   phase;
        logic saw_cmd;
        e.fault = exp_fault;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_is_fetch = fetch;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        edges   = 0;
        waited  = 0;
        phase   = 0;
        saw_cmd = 1'b0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (phase == 1) begin
                mem_cmd_ready = 1'b0;
                phase = 2;
                if (give_rsp && !we) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rsp_word;
                end
            end
            if (mem_cmd_valid) begin
                saw_cmd = 1'b1;
                chk({nm, "_addr"},  mem_addr, addr & 32'hFFFF_FFFC);
                chk({nm, "_be"},    {28'd0, mem_be}, {28'd0, exp_be});
                chk({nm, "_we"},    {31'd0, mem_we}, {31'd0, we});
                if (we) chk({nm, "_wdata"}, mem_wdata, exp_wdata);
                if (waited < rdy_dly) begin
                    mem_cmd_ready = 1'b0;
                    waited++;
                end else begin
                    mem_cmd_ready = 1'b1;
                    phase = 1;
                end
            end
            if (done) break;
            if (edges > 400) begin
                chk({nm, "_done_timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        req_valid     = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk({nm, "_latency"}, edges, exp_edges);
        chk({nm, "_cmd_issued"}, {31'd0, saw_cmd}, {31'd0, exp_cmd});
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_is_fetch  = 1'b0;
        req_funct3    = 3'd0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_done",  {31'd0, done},          32'd0);
        chk("rst_fault", {31'd0, fault},         32'd0);
        chk("rst_cmdv",  {31'd0, mem_cmd_valid}, 32'd0);
        chk("rst_be",    {28'd0, mem_be},        32'd0);
        chk("rst_rdata", rdata,                  32'd0);
        chk("rst_addr",  mem_addr,               32'd0);
        chk("rst_wdata", mem_wdata,              32'd0);
        rst_n = 1'b1;

        //        name    we    fch   f3    addr           wdata          dly rsp  rsp_word       flt   exp_rd         cmd   be       exp_wdata      edges
        do_access("fetch", 1'b0, 1'b1, 3'd7, 32'h0000_0010, 32'h0,         0, 1'b1, 32'h0051_0513, 1'b0, 32'h0051_0513, 1'b1, 4'hF,    32'h0,         3);
        do_access("sb",    1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 1'b0, 32'h0,         1'b0, 32'h0051_0513, 1'b1, 4'b1000, 32'hA5A5_A5A5, 2);
        do_access("lb",    1'b0, 1'b0, 3'd0, 32'h0000_0102, 32'h0,         0, 1'b1, 32'h1280_3456, 1'b0, 32'hFFFF_FF80, 1'b1, 4'hF,    32'h0,         3);
        do_access("lbu",   1'b0, 1'b0, 3'd4, 32'h0000_0102, 32'h0,         0, 1'b1, 32'h1280_3456, 1'b0, 32'h0000_0080, 1'b1, 4'hF,    32'h0,         3);
        do_access("lhu",   1'b0, 1'b0, 3'd5, 32'h0000_0102, 32'h0,         0, 1'b1, 32'h1280_3456, 1'b0, 32'h0000_1280, 1'b1, 4'hF,    32'h0,         3);
        do_access("lh",    1'b0, 1'b0, 3'd1, 32'h0000_0100, 32'h0,         0, 1'b1, 32'h1280_F456, 1'b0, 32'hFFFF_F456, 1'b1, 4'hF,    32'h0,         3);
        do_access("lb_pos",1'b0, 1'b0, 3'd0, 32'h0000_0101, 32'h0,         0, 1'b1, 32'h0000_7F00, 1'b0, 32'h0000_007F, 1'b1, 4'hF,    32'h0,         3);
        do_access("lw",    1'b0, 1'b0, 3'd2, 32'h0000_0104, 32'h0,         0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b1, 4'hF,    32'h0,         3);
        do_access("sh",    1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0000_BEEF, 0, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, 4'b1100, 32'hBEEF_BEEF, 2);
        do_access("sb1",   1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'h1234_5677, 0, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, 4'b0010, 32'h7777_7777, 2);
        do_access("lw_mis",1'b0, 1'b0, 3'd2, 32'h0000_0102, 32'h0,         0, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 4'h0,    32'h0,         1);
        do_access("sh_mis",1'b1, 1'b0, 3'd1, 32'h0000_0101, 32'h0,         0, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 4'h0,    32'h0,         1);
        do_access("ld_f3", 1'b0, 1'b0, 3'd3, 32'h0000_0100, 32'h0,         0, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 4'h0,    32'h0,         1);
        do_access("st_f3", 1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0,         0, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 4'h0,    32'h0,         1);
        do_access("if_mis",1'b0, 1'b1, 3'd0, 32'h0000_0012, 32'h0,         0, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 4'h0,    32'h0,         1);
        do_access("sw_dly",1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 5, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, 4'hF,    32'hDEAD_BEEF, 7);
        do_access("tmo",   1'b0, 1'b0, 3'd2, 32'h0000_0300, 32'h0,         5, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b1, 4'hF,    32'h0,         263);

        // Reset while waiting for a read response; the late response must be ignored
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            req_valid    = 1'b1;
            req_we       = 1'b0;
            req_is_fetch = 1'b0;
            req_funct3   = 3'd2;
            req_addr     = 32'h0000_0400;
            while (!mem_cmd_valid && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            chk("rstw_cmd_seen", {31'd0, mem_cmd_valid}, 32'd1);
            mem_cmd_ready = 1'b1;
            @(negedge clk);
            mem_cmd_ready = 1'b0;
            repeat (3) @(negedge clk);
            rst_n     = 1'b0;
            req_valid = 1'b0;
            #1;
            chk("rstw_done",  {31'd0, done},          32'd0);
            chk("rstw_fault", {31'd0, fault},         32'd0);
            chk("rstw_cmdv",  {31'd0, mem_cmd_valid}, 32'd0);
            chk("rstw_addr",  mem_addr,               32'd0);
            chk("rstw_rdata", rdata,                  32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h5555_AAAA;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("late_done",  {31'd0, done},          32'd0);
                chk("late_cmdv",  {31'd0, mem_cmd_valid}, 32'd0);
                chk("late_rdata", rdata,                  32'd0);
                @(negedge clk);
            end
        end

        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
